// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the ID-stage hazard scoreboard: register address, ID-side request and
// issue-control response.
package hazard_scoreboard_pkg;

  // Wide enough for a 32-entry register file; narrower files zero-extend into it.
  localparam int unsigned CregW = 5;

  typedef logic [CregW-1:0] creg_addr_t;

  typedef struct packed {
    logic       valid;
    creg_addr_t ra1;
    creg_addr_t ra2;
    logic       use1;
    logic       use2;
    logic       wen;
    creg_addr_t dst;
    logic       md;
    logic       jump;
  } hazard_in_t;

  typedef struct packed {
    logic issue;
    logic stall;
    logic bubble;
    logic flush_ifid;
  } hazard_out_t;

endpackage

// File: rtl/hazard_pending_cnt.sv
// Saturating up/down counter tracking outstanding writes to one architectural register.
module hazard_pending_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel; both ends clamp.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && (|cnt_q)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: RAW/full/multi-cycle-unit interlocks and pipeline controls.
// Define HAZARD_SCOREBOARD_PERF_EN to add the saturating perf_stall cycle counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREG   = 32,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned MD_LAT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [$clog2(NREG)-1:0] id_ra1,
  input  logic [$clog2(NREG)-1:0] id_ra2,
  input  logic                    id_use1,
  input  logic                    id_use2,
  input  logic                    id_wen,
  input  logic [$clog2(NREG)-1:0] id_dst,
  input  logic                    id_md,
  input  logic                    id_jump,
  input  logic                    ex_redirect,
  input  logic                    wb_valid,
  input  logic [$clog2(NREG)-1:0] wb_dst,
  input  logic                    iwait,
  input  logic                    dwait,
  output logic                    issue,
  output logic                    stall,
  output logic                    bubble,
  output logic                    flush_ifid,
  output logic                    md_busy,
  output logic                    pending_any
`ifdef HAZARD_SCOREBOARD_PERF_EN
  ,
  output logic [63:0]             perf_stall
`endif
);

  localparam int unsigned AW  = $clog2(NREG);
  localparam int unsigned MdW = $clog2(MD_LAT) + 1;

  hazard_in_t  hin;
  hazard_out_t hout;

  logic [NREG-1:0] nz;
  logic [NREG-1:0] at_max;
  logic [MdW-1:0]  md_cnt_q, md_cnt_d;
  logic            raw, full, mdh, freeze;

  always_comb begin
    hin       = '0;
    hin.valid = id_valid;
    hin.ra1   = creg_addr_t'(id_ra1);
    hin.ra2   = creg_addr_t'(id_ra2);
    hin.use1  = id_use1;
    hin.use2  = id_use2;
    hin.wen   = id_wen;
    hin.dst   = creg_addr_t'(id_dst);
    hin.md    = id_md;
    hin.jump  = id_jump;
  end

  assign nz[0]     = 1'b0;
  assign at_max[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic [CNT_W-1:0] cnt_r;

    hazard_pending_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (hout.issue & hin.wen & (hin.dst == CregW'(r))),
      .dec  (wb_valid & (wb_dst == AW'(r))),
      .cnt  (cnt_r)
    );

    assign nz[r]     = |cnt_r;
    assign at_max[r] = &cnt_r;
  end

  // Hazards look only at registered counters, so a same-cycle writeback never unblocks.
  assign raw    = (hin.use1 & (hin.ra1 != '0) & nz[hin.ra1]) |
                  (hin.use2 & (hin.ra2 != '0) & nz[hin.ra2]);
  assign full   = hin.wen & (hin.dst != '0) & at_max[hin.dst];
  assign mdh    = hin.md & (md_cnt_q != '0);
  assign freeze = iwait | dwait;

  always_comb begin
    hout.issue      = ~reset & hin.valid & ~raw & ~full & ~mdh & ~freeze & ~ex_redirect;
    hout.stall      = reset | freeze | (hin.valid & ~hout.issue & ~ex_redirect);
    hout.bubble     = reset | (~hout.issue & ~dwait);
    hout.flush_ifid = ~reset & (ex_redirect | (hout.issue & hin.jump));
  end

  assign issue       = hout.issue;
  assign stall       = hout.stall;
  assign bubble      = hout.bubble;
  assign flush_ifid  = hout.flush_ifid;
  assign md_busy     = ~reset & (md_cnt_q != '0);
  assign pending_any = ~reset & (|nz);

  // The multi-cycle unit freezes along with the data side.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (hout.issue && hin.md) begin
      md_cnt_d = MdW'(MD_LAT - 1);
    end else if (md_cnt_q != '0 && !dwait) begin
      md_cnt_d = md_cnt_q - MdW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [63:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (hin.valid && !hout.issue && !ex_redirect && !(&perf_q)) begin
      perf_q <= perf_q + 64'd1;
    end
  end

  assign perf_stall = perf_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scenario bench for hazard_scoreboard: each step queues the expected control vector
// {issue, stall, bubble, flush_ifid, md_busy, pending_any}, then compares the DUT output.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use1, id_use2, id_wen, id_md, id_jump;
  logic [4:0] id_ra1, id_ra2, id_dst, wb_dst;
  logic       ex_redirect, wb_valid, iwait, dwait;
  logic       issue, stall, bubble, flush_ifid, md_busy, pending_any;
`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [63:0] perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];

  hazard_scoreboard #(
    .NREG  (32),
    .CNT_W (2),
    .MD_LAT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_ra1     (id_ra1),
    .id_ra2     (id_ra2),
    .id_use1    (id_use1),
    .id_use2    (id_use2),
    .id_wen     (id_wen),
    .id_dst     (id_dst),
    .id_md      (id_md),
    .id_jump    (id_jump),
    .ex_redirect(ex_redirect),
    .wb_valid   (wb_valid),
    .wb_dst     (wb_dst),
    .iwait      (iwait),
    .dwait      (dwait),
    .issue      (issue),
    .stall      (stall),
    .bubble     (bubble),
    .flush_ifid (flush_ifid),
    .md_busy    (md_busy),
    .pending_any(pending_any)
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_in();
    reset = 0; id_valid = 0; id_use1 = 0; id_use2 = 0; id_wen = 0; id_md = 0; id_jump = 0;
    id_ra1 = 0; id_ra2 = 0; id_dst = 0; wb_dst = 0;
    ex_redirect = 0; wb_valid = 0; iwait = 0; dwait = 0;
  endtask

  // Inputs are already set 1ns after a rising edge; sample mid-cycle, then advance.
  task automatic step(input logic [5:0] exp);
    exp_q.push_back(exp);
    #4;
    obs_q.push_back({issue, stall, bubble, flush_ifid, md_busy, pending_any});
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic rd(input logic [4:0] a);
    id_valid = 1; id_use1 = 1; id_ra1 = a;
  endtask

  task automatic wr(input logic [4:0] d);
    id_valid = 1; id_wen = 1; id_dst = d;
  endtask

  task automatic test_reset();
    logic [5:0] e, o;
    int k = 0;
    reset = 1; rd(5'd1);          step(6'b011000);
    clear_in();                   step(6'b001000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL reset step %0d: got %b expected %b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_raw();
    logic [5:0] e, o;
    int k = 0;
    wr(5'd5);                                  step(6'b100000);
    rd(5'd5);                                  step(6'b011001);
    rd(5'd5);                                  step(6'b011001);
    id_valid = 1; id_use2 = 1; id_ra2 = 5'd5;  step(6'b011001);
    rd(5'd5); wb_valid = 1; wb_dst = 5'd5;     step(6'b011001);
    rd(5'd5);                                  step(6'b100000);
    step(6'b001000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL raw step %0d: got %b expected %b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_full();
    logic [5:0] e, o;
    int k = 0;
    wr(5'd7);                               step(6'b100000);
    wr(5'd7);                               step(6'b100001);
    wr(5'd7);                               step(6'b100001);
    wr(5'd7);                               step(6'b011001);
    wr(5'd7); wb_valid = 1; wb_dst = 5'd7;  step(6'b011001);
    wr(5'd7);                               step(6'b100001);
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1; wb_dst = 5'd7;          step(6'b001001);
    end
    step(6'b001000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL full step %0d: got %b expected %b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_md();
    logic [5:0] e, o;
    int k = 0;
    id_valid = 1; id_md = 1;                 step(6'b100000);
    for (int i = 0; i < 3; i++) begin
      id_valid = 1; id_md = 1;               step(6'b011010);
    end
    id_valid = 1; id_md = 1;                 step(6'b100000);
    for (int i = 0; i < 3; i++)              step(6'b001010);
    step(6'b001000);
    // Same pair with the data side frozen for two cycles.
    id_valid = 1; id_md = 1;                 step(6'b100000);
    id_valid = 1; id_md = 1; dwait = 1;      step(6'b010010);
    id_valid = 1; id_md = 1; dwait = 1;      step(6'b010010);
    for (int i = 0; i < 3; i++) begin
      id_valid = 1; id_md = 1;               step(6'b011010);
    end
    id_valid = 1; id_md = 1;                 step(6'b100000);
    for (int i = 0; i < 3; i++)              step(6'b001010);
    step(6'b001000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL md step %0d: got %b expected %b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_redirect();
    logic [5:0] e, o;
    int k = 0;
    wr(5'd4);                                step(6'b100000);
    rd(5'd4);                                step(6'b011001);
    rd(5'd4); id_wen = 1; id_dst = 5'd6; ex_redirect = 1; step(6'b001101);
    rd(5'd4);                                step(6'b011001);
    wb_valid = 1; wb_dst = 5'd4;             step(6'b001001);
    id_valid = 1; id_jump = 1;               step(6'b100100);
    iwait = 1; id_valid = 1;                 step(6'b011000);
    step(6'b001000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL redirect step %0d: got %b expected %b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_same_cycle();
    logic [5:0] e, o;
    int k = 0;
    wr(5'd9);                                step(6'b100000);
    wr(5'd9); wb_valid = 1; wb_dst = 5'd9;   step(6'b100001);
    rd(5'd9);                                step(6'b011001);
    wb_valid = 1; wb_dst = 5'd9;             step(6'b001001);
    rd(5'd9);                                step(6'b100000);
    // x0 is never tracked.
    wr(5'd0);                                step(6'b100000);
    rd(5'd0);                                step(6'b100000);
    // Writeback to an idle register must not wrap its counter.
    wb_valid = 1; wb_dst = 5'd12;            step(6'b001000);
    wr(5'd12);                               step(6'b100000);
    rd(5'd12);                               step(6'b011001);
    wb_valid = 1; wb_dst = 5'd12;            step(6'b001001);
    step(6'b001000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL same_cycle step %0d: got %b expected %b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] e, o;
    int k = 0;
    wr(5'd3);                                step(6'b100000);
    wr(5'd3);                                step(6'b100001);
    id_valid = 1; id_md = 1;                 step(6'b100001);
    reset = 1; rd(5'd3);                     step(6'b011000);
    rd(5'd3);                                step(6'b100000);
    step(6'b001000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL reset_mid step %0d: got %b expected %b", k, o, e);
      end
      k++;
    end
  endtask

  initial begin
    clear_in();
    reset = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_raw();
    test_full();
    test_md();
    test_redirect();
    test_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
